// File: rtl/pmu_quota_multi.sv
// -----------------------------------------------------------------------------
// pmu_quota_multi
//
// Multi-core quota monitor for the PMU. It sits between the event-counter bank
// and the PMU interrupt aggregator.
//
// A shared sequencer visits one event counter per cycle. Each of the N_CORES
// quota channels adds the visited counter to its own accumulator when that
// counter is enabled in the channel's mask. At the end of every sweep the
// accumulator is committed to a stable per-core sum. The sum is compared with
// the channel limit, and a sticky interrupt is raised when the sum is strictly
// greater than the limit.
//
// Ports
//   clk_i            clock
//   rstn_i           asynchronous active-low reset
//   softrst_i        synchronous active-high soft reset; overrides all other inputs
//   counter_value_i  packed event counters, counter k at [k*REG_WIDTH +: REG_WIDTH]
//   quota_mask_i     per-core counter masks, core c at [c*N_COUNTERS +: N_COUNTERS]
//   quota_limit_i    per-core limits, core c at [c*SUM_W +: SUM_W]
//   intr_clear_i     per-core sticky-interrupt clear (1-cycle pulse)
//   quota_sum_o      last committed sum per core, core c at [c*SUM_W +: SUM_W]
//   sweep_done_o     1-cycle pulse, concurrent with freshly committed sums
//   intr_quota_o     sticky per-core quota-exceeded interrupt
// -----------------------------------------------------------------------------
module pmu_quota_multi #(
    parameter int  REG_WIDTH  = 32,
    parameter int  N_COUNTERS = 9,
    parameter int  N_CORES    = 4,
    localparam int SUM_W      = $clog2(N_COUNTERS) + REG_WIDTH,
    localparam int IDX_W      = $clog2(N_COUNTERS)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          softrst_i,
    input  logic [N_COUNTERS*REG_WIDTH-1:0] counter_value_i,
    input  logic [N_CORES*N_COUNTERS-1:0] quota_mask_i,
    input  logic [N_CORES*SUM_W-1:0]      quota_limit_i,
    input  logic [N_CORES-1:0]            intr_clear_i,
    output logic [N_CORES*SUM_W-1:0]      quota_sum_o,
    output logic                          sweep_done_o,
    output logic [N_CORES-1:0]            intr_quota_o
);

    // -------------------------------------------------------------------------
    // Shared sequencer: free-running counter index, never stalls.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 sweep_done_q, sweep_done_d;
    logic                 last_idx;
    logic [REG_WIDTH-1:0] cur_counter;

    assign last_idx    = (idx_q == IDX_W'(N_COUNTERS - 1));
    assign cur_counter = counter_value_i[int'(idx_q)*REG_WIDTH +: REG_WIDTH];

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        idx_d        = last_idx ? '0 : idx_q + IDX_W'(1);
        sweep_done_d = last_idx;
    end

    // NOTE: asynchronous reset is listed in the sensitivity list and tested first;
    // the synchronous soft reset is an ordinary priority branch under the clock.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_q        <= '0;
            sweep_done_q <= 1'b0;
        end else if (softrst_i) begin
            idx_q        <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            idx_q        <= idx_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign sweep_done_o = sweep_done_q;

    // -------------------------------------------------------------------------
    // Per-core quota channels. Channels share only the sequencer and never
    // influence one another.
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        logic [N_COUNTERS-1:0] mask_c;
        logic [N_COUNTERS-1:0] old_mask_q;
        logic [SUM_W-1:0]      limit_c;
        logic [SUM_W-1:0]      v_c;
        logic [SUM_W-1:0]      acc_q, acc_d;
        logic [SUM_W-1:0]      sum_q, sum_d;
        logic                  skip_q, skip_d;
        logic                  intr_q, intr_d;
        logic                  set_c;

        assign mask_c  = quota_mask_i[c*N_COUNTERS +: N_COUNTERS];
        assign limit_c = quota_limit_i[c*SUM_W +: SUM_W];
        assign v_c     = mask_c[idx_q] ? SUM_W'(cur_counter) : '0;

        always_comb begin
            acc_d  = acc_q;
            sum_d  = sum_q;
            skip_d = skip_q;
            if (mask_c != old_mask_q) begin
                // A mask change discards the sweep in progress; skip_q also blocks
                // the commit at the end of this sweep, so the next committed sum
                // covers a complete sweep taken with a stable mask.
                acc_d  = '0;
                skip_d = 1'b1;
            end else if (last_idx) begin
                if (!skip_q) begin
                    sum_d = acc_q + v_c;
                end
                acc_d  = '0;
                skip_d = 1'b0;
            end else begin
                acc_d = acc_q + v_c;
            end
        end

        // The compare uses the registered sum with the live limit. A lowered limit
        // therefore fires without waiting for the next sweep. Set beats clear.
        assign set_c  = (sum_q > limit_c);
        assign intr_d = set_c | (intr_q & ~intr_clear_i[c]);

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                acc_q      <= '0;
                sum_q      <= '0;
                skip_q     <= 1'b0;
                intr_q     <= 1'b0;
                old_mask_q <= '0;
            end else if (softrst_i) begin
                acc_q      <= '0;
                sum_q      <= '0;
                skip_q     <= 1'b0;
                intr_q     <= 1'b0;
                // Capturing the live mask lets the first sweep after a soft reset commit.
                old_mask_q <= mask_c;
            end else begin
                acc_q      <= acc_d;
                sum_q      <= sum_d;
                skip_q     <= skip_d;
                intr_q     <= intr_d;
                old_mask_q <= mask_c;
            end
        end

        assign quota_sum_o[c*SUM_W +: SUM_W] = sum_q;
        assign intr_quota_o[c]               = intr_q;
    end

endmodule

// File: tb/tb_pmu_quota_multi.sv
// -----------------------------------------------------------------------------
// tb_pmu_quota_multi
//
// Directed bench for pmu_quota_multi. It uses two instances:
//   dut4: N_COUNTERS=4, SUM_W=34. Counters are {10,20,30,40}.
//   dut9: N_COUNTERS=9, SUM_W=36. All counters are all-ones, so the
//         no-overflow width can be observed.
// Outputs are sampled on the falling edge. Inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_pmu_quota_multi;

    localparam int RW = 32;
    localparam int NC = 4;
    localparam int N4 = 4;
    localparam int S4 = 34;
    localparam int N9 = 9;
    localparam int S9 = 36;

    localparam logic [S9-1:0] FULL9 = 36'h8_FFFF_FFF7;  // 9 * (2^32 - 1)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic softrst;

    logic [N4*RW-1:0] cnt4;
    logic [NC*N4-1:0] mask4;
    logic [NC*S4-1:0] lim4;
    logic [NC-1:0]    clr4;
    logic [NC*S4-1:0] sum4;
    logic             done4;
    logic [NC-1:0]    intr4;

    logic [N9*RW-1:0] cnt9;
    logic [NC*N9-1:0] mask9;
    logic [NC*S9-1:0] lim9;
    logic [NC-1:0]    clr9;
    logic [NC*S9-1:0] sum9;
    logic             done9;
    logic [NC-1:0]    intr9;

    int checks   = 0;
    int failures = 0;

    pmu_quota_multi #(.REG_WIDTH(RW), .N_COUNTERS(N4), .N_CORES(NC)) dut4 (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .softrst_i      (softrst),
        .counter_value_i(cnt4),
        .quota_mask_i   (mask4),
        .quota_limit_i  (lim4),
        .intr_clear_i   (clr4),
        .quota_sum_o    (sum4),
        .sweep_done_o   (done4),
        .intr_quota_o   (intr4)
    );

    pmu_quota_multi #(.REG_WIDTH(RW), .N_COUNTERS(N9), .N_CORES(NC)) dut9 (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .softrst_i      (softrst),
        .counter_value_i(cnt9),
        .quota_mask_i   (mask9),
        .quota_limit_i  (lim9),
        .intr_clear_i   (clr9),
        .quota_sum_o    (sum9),
        .sweep_done_o   (done9),
        .intr_quota_o   (intr9)
    );

    function automatic logic [S4-1:0] s4(input int c);
        return sum4[c*S4 +: S4];
    endfunction

    function automatic logic [S9-1:0] s9(input int c);
        return sum9[c*S9 +: S9];
    endfunction

    // Waits for the next sweep_done pulse. The cycle count includes the
    // falling edge on which the pulse is seen.
    task automatic wait_done4(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done4 && cycles < 40);
        checks++;
        if (done4 !== 1'b1) begin
            failures++;
            $display("FAIL wait_done4: sweep_done=%0b after %0d cycles, required 1", done4, cycles);
        end
    endtask

    task automatic wait_done9(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done9 && cycles < 40);
        checks++;
        if (done9 !== 1'b1) begin
            failures++;
            $display("FAIL wait_done9: sweep_done=%0b after %0d cycles, required 1", done9, cycles);
        end
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        softrst = 1'b0;
        cnt4    = {32'd40, 32'd30, 32'd20, 32'd10};
        mask4   = {4'b1000, 4'b0010, 4'b0001, 4'b1111};
        lim4    = {34'd1000, 34'd1000, 34'd1000, 34'd99};
        clr4    = '0;
        cnt9    = '1;
        mask9   = '1;
        lim9    = {36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, FULL9, FULL9 - 36'd1};
        clr9    = '0;
        #1;
        checks++;
        if (sum4 !== '0) begin
            failures++; $display("FAIL reset_sum4: got %h expected 0", sum4);
        end
        checks++;
        if (intr4 !== 4'b0000 || done4 !== 1'b0) begin
            failures++; $display("FAIL reset_intr_done4: got intr=%b done=%b expected 0000/0", intr4, done4);
        end
        checks++;
        if (sum9 !== '0 || intr9 !== 4'b0000) begin
            failures++; $display("FAIL reset_dut9: got sum=%h intr=%b expected 0/0000", sum9, intr9);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        // After a hard reset old_mask is 0, so the first sweep counts as a mask change and is discarded.
        wait_done4(n);
        checks++;
        if (s4(0) !== 34'd0) begin
            failures++; $display("FAIL basic_first_sweep_discarded: got %0d expected 0", s4(0));
        end
        wait_done4(n);
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL basic_period: got %0d cycles expected 4", n);
        end
        checks++;
        if (s4(0) !== 34'd100) begin
            failures++; $display("FAIL basic_sum0: got %0d expected 100", s4(0));
        end
        checks++;
        if (s4(1) !== 34'd10 || s4(2) !== 34'd20 || s4(3) !== 34'd40) begin
            failures++; $display("FAIL basic_sum123: got %0d/%0d/%0d expected 10/20/40", s4(1), s4(2), s4(3));
        end
        checks++;
        if (intr4 !== 4'b0000) begin
            failures++; $display("FAIL basic_intr_at_commit: got %b expected 0000", intr4);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse_width: got %b expected 0", done4);
        end
        checks++;
        if (intr4 !== 4'b0001) begin
            failures++; $display("FAIL basic_intr_next_cycle: got %b expected 0001", intr4);
        end
    endtask

    task automatic test_clear();
        clr4 = 4'b0001;
        @(negedge clk);
        clr4 = 4'b0000;
        checks++;
        if (intr4[0] !== 1'b1) begin
            failures++; $display("FAIL clear_set_wins: got %b expected 1", intr4[0]);
        end
        lim4[0 +: S4] = 34'd200;
        clr4 = 4'b0001;
        @(negedge clk);
        clr4 = 4'b0000;
        checks++;
        if (intr4[0] !== 1'b0) begin
            failures++; $display("FAIL clear_takes_effect: got %b expected 0", intr4[0]);
        end
        @(negedge clk);
        checks++;
        if (intr4 !== 4'b0000) begin
            failures++; $display("FAIL clear_stays_low: got %b expected 0000", intr4);
        end
        // A lowered limit fires on the stored sum without waiting for a sweep.
        lim4[0 +: S4] = 34'd50;
        @(negedge clk);
        checks++;
        if (intr4[0] !== 1'b1) begin
            failures++; $display("FAIL lowered_limit: got %b expected 1", intr4[0]);
        end
    endtask

    task automatic test_equality();
        int n;
        lim4[0 +: S4] = 34'd100;
        clr4 = 4'b0001;
        @(negedge clk);
        clr4 = 4'b0000;
        checks++;
        if (intr4[0] !== 1'b0) begin
            failures++; $display("FAIL equality_clear: got %b expected 0", intr4[0]);
        end
        wait_done4(n);
        checks++;
        if (s4(0) !== 34'd100) begin
            failures++; $display("FAIL equality_sum0: got %0d expected 100", s4(0));
        end
        @(negedge clk);
        checks++;
        if (intr4[0] !== 1'b0) begin
            failures++; $display("FAIL equality_no_fire: got %b expected 0", intr4[0]);
        end
    endtask

    task automatic test_mask_change();
        int n;
        wait_done4(n);          // this cycle the sequencer is on index 0
        @(negedge clk);         // index 1
        @(negedge clk);         // index 2
        mask4[1*N4 +: N4] = 4'b0110;
        wait_done4(n);
        checks++;
        if (n != 2) begin
            failures++; $display("FAIL mask_done_timing: got %0d cycles expected 2", n);
        end
        checks++;
        if (s4(1) !== 34'd10) begin
            failures++; $display("FAIL mask_commit_suppressed: got %0d expected 10", s4(1));
        end
        checks++;
        if (s4(0) !== 34'd100 || s4(2) !== 34'd20 || s4(3) !== 34'd40) begin
            failures++; $display("FAIL mask_other_cores: got %0d/%0d/%0d expected 100/20/40", s4(0), s4(2), s4(3));
        end
        wait_done4(n);
        checks++;
        if (s4(1) !== 34'd50) begin
            failures++; $display("FAIL mask_next_commit: got %0d expected 50", s4(1));
        end
        checks++;
        if (s4(0) !== 34'd100 || s4(3) !== 34'd40 || intr4 !== 4'b0000) begin
            failures++; $display("FAIL mask_independence: got %0d/%0d intr=%b expected 100/40/0000", s4(0), s4(3), intr4);
        end
    endtask

    task automatic test_wide();
        int n;
        wait_done9(n);
        wait_done9(n);
        checks++;
        if (n != 9) begin
            failures++; $display("FAIL wide_period: got %0d cycles expected 9", n);
        end
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (s9(c) !== FULL9) begin
                failures++; $display("FAIL wide_sum core%0d: got %h expected %h", c, s9(c), FULL9);
            end
        end
        @(negedge clk);
        checks++;
        if (intr9 !== 4'b0001) begin
            failures++; $display("FAIL wide_intr: got %b expected 0001", intr9);
        end
    endtask

    task automatic test_softrst();
        int n;
        lim4[0 +: S4] = 34'd99;
        @(negedge clk);
        checks++;
        if (intr4[0] !== 1'b1) begin
            failures++; $display("FAIL softrst_precondition: got %b expected 1", intr4[0]);
        end
        wait_done4(n);
        @(negedge clk);         // mid-sweep, index 1
        softrst = 1'b1;
        @(negedge clk);
        softrst = 1'b0;
        checks++;
        if (sum4 !== '0 || intr4 !== 4'b0000 || done4 !== 1'b0) begin
            failures++; $display("FAIL softrst_clear: got sum=%h intr=%b done=%b expected 0/0000/0", sum4, intr4, done4);
        end
        checks++;
        if (sum9 !== '0 || intr9 !== 4'b0000) begin
            failures++; $display("FAIL softrst_dut9: got sum=%h intr=%b expected 0/0000", sum9, intr9);
        end
        wait_done4(n);
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL softrst_first_done: got %0d cycles expected 4", n);
        end
        // The soft reset captured the live mask, so this first sweep commits.
        checks++;
        if (s4(0) !== 34'd100 || s4(1) !== 34'd50) begin
            failures++; $display("FAIL softrst_first_commit: got %0d/%0d expected 100/50", s4(0), s4(1));
        end
        @(negedge clk);
        checks++;
        if (intr4 !== 4'b0001) begin
            failures++; $display("FAIL softrst_intr_refire: got %b expected 0001", intr4);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;                     // clock is low; no edge until the next rising edge
        rstn = 1'b0;
        #1;
        checks++;
        if (sum4 !== '0 || intr4 !== 4'b0000) begin
            failures++; $display("FAIL async_reset: got sum=%h intr=%b expected 0/0000", sum4, intr4);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_equality();
        test_mask_change();
        test_wide();
        test_softrst();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
